// File: rtl/mbist_scheduler_if.sv
// Scheduler-to-engine bus: launch configuration out, run status back.
interface mbist_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic                  test_mode;
  logic [2:0]            operation;
  logic [2:0]            memory_sel;
  logic [4:0]            memtype;
  logic [ADDR_WIDTH-1:0] allowable_faulty;
  logic                  error_exceed_ignore;
  logic                  error;
  logic                  force_terminate;
  logic                  complete;

  // Scheduler side
  modport master (
    output test_mode, operation, memory_sel, memtype, allowable_faulty, error_exceed_ignore,
    input  error, force_terminate, complete
  );

  // Engine side
  modport slave (
    input  test_mode, operation, memory_sel, memtype, allowable_faulty, error_exceed_ignore,
    output error, force_terminate, complete
  );
endinterface

// File: rtl/mbist_scheduler.sv
// MBIST session sequencer: walks enabled memories, launches the engine on each one,
// and collects per-memory pass/fail/timeout/errored status plus an error count.
module mbist_scheduler #(
  parameter int unsigned NUM_MEM    = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CFG_CYCLES = 4,
  parameter int unsigned TO_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_MEM-1:0]      mem_enable,
  input  logic [2:0]              algo_sel,
  input  logic [5*NUM_MEM-1:0]    memtype_cfg,
  input  logic [ADDR_WIDTH-1:0]   allowable_faulty_cfg,
  input  logic                    ignore_cfg,
  input  logic [TO_WIDTH-1:0]     timeout_cycles,
  mbist_scheduler_if.master       eng,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [2:0]              cur_mem,
  output logic [NUM_MEM-1:0]      pass_mask,
  output logic [NUM_MEM-1:0]      fail_mask,
  output logic [NUM_MEM-1:0]      timeout_mask,
  output logic [NUM_MEM-1:0]      errored_mask,
  output logic [15:0]             err_count
);

  localparam int unsigned CntW = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StSelect, StConfig, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MEM-1:0]     remaining_q, remaining_d;
  logic [2:0]             algo_q, algo_d;
  logic [5*NUM_MEM-1:0]   memtype_cfg_q, memtype_cfg_d;
  logic [ADDR_WIDTH-1:0]  af_cfg_q, af_cfg_d;
  logic                   ign_cfg_q, ign_cfg_d;
  logic [TO_WIDTH-1:0]    to_q, to_d;
  logic [CntW-1:0]        cfg_cnt_q, cfg_cnt_d;
  logic [TO_WIDTH-1:0]    wd_q, wd_d;
  logic                   err_prev_q, err_prev_d;

  logic                   test_mode_q, test_mode_d;
  logic [2:0]             operation_q, operation_d;
  logic [2:0]             cur_mem_q, cur_mem_d;
  logic [4:0]             memtype_q, memtype_d;
  logic [ADDR_WIDTH-1:0]  af_q, af_d;
  logic                   eei_q, eei_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic [NUM_MEM-1:0]     pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, errd_q, errd_d;
  logic [15:0]            err_count_q, err_count_d;

  logic                   sel_found;
  logic [2:0]             sel_idx;
  logic                   abort_hit, ev_to, run_exit, err_rise;

  // Lowest set bit of the remaining-memory mask
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = int'(NUM_MEM) - 1; i >= 0; i--) begin
      if (remaining_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  assign abort_hit = abort && (state_q inside {StSelect, StConfig, StRun});
  // Watchdog fires on the RUN cycle whose 1-based index equals timeout
  assign ev_to     = (to_q != '0) && (wd_q == to_q - TO_WIDTH'(1));
  assign run_exit  = eng.force_terminate || eng.complete || ev_to;
  assign err_rise  = eng.error && !err_prev_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; abort outranks every engine event
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSelect;
      StSelect: state_d = (abort || !sel_found) ? StDone : StConfig;
      StConfig: begin
        if (abort)                                     state_d = StDone;
        else if (cfg_cnt_q == CntW'(CFG_CYCLES - 1))   state_d = StRun;
      end
      StRun: begin
        if (abort)         state_d = StDone;
        else if (run_exit) state_d = StSelect;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next-state; every output is a flop fed from here
  always_comb begin
    remaining_d   = remaining_q;
    algo_d        = algo_q;
    memtype_cfg_d = memtype_cfg_q;
    af_cfg_d      = af_cfg_q;
    ign_cfg_d     = ign_cfg_q;
    to_d          = to_q;
    operation_d   = operation_q;
    cur_mem_d     = cur_mem_q;
    memtype_d     = memtype_q;
    af_d          = af_q;
    eei_d         = eei_q;
    aborted_d     = aborted_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    tmo_d         = tmo_q;
    errd_d        = errd_q;
    err_count_d   = err_count_q;
    err_prev_d    = eng.error;
    cfg_cnt_d     = (state_q == StConfig) ? cfg_cnt_q + CntW'(1) : '0;
    wd_d          = (state_q == StRun) ? wd_q + TO_WIDTH'(1) : '0;
    test_mode_d   = (state_d == StConfig);
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d   = mem_enable;
          algo_d        = algo_sel;
          memtype_cfg_d = memtype_cfg;
          af_cfg_d      = allowable_faulty_cfg;
          ign_cfg_d     = ignore_cfg;
          to_d          = timeout_cycles;
          pass_d        = '0;
          fail_d        = '0;
          tmo_d         = '0;
          errd_d        = '0;
          err_count_d   = '0;
          aborted_d     = 1'b0;
        end
      end
      StSelect: begin
        if (!abort && sel_found) begin
          remaining_d[sel_idx] = 1'b0;
          cur_mem_d            = sel_idx;
          operation_d          = algo_q;
          memtype_d            = memtype_cfg_q[5*sel_idx +: 5];
          af_d                 = af_cfg_q;
          eei_d                = ign_cfg_q;
        end
      end
      StRun: begin
        if (!abort) begin
          if (eng.force_terminate)  fail_d[cur_mem_q] = 1'b1;
          else if (eng.complete)    pass_d[cur_mem_q] = 1'b1;
          else if (ev_to)           tmo_d[cur_mem_q]  = 1'b1;
        end
      end
      default: ;
    endcase

    if ((state_q == StConfig || state_q == StRun) && err_rise) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      errd_d[cur_mem_q] = 1'b1;
    end

    if (abort_hit) aborted_d = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q   <= '0;
      algo_q        <= '0;
      memtype_cfg_q <= '0;
      af_cfg_q      <= '0;
      ign_cfg_q     <= 1'b0;
      to_q          <= '0;
      cfg_cnt_q     <= '0;
      wd_q          <= '0;
      err_prev_q    <= 1'b0;
      test_mode_q   <= 1'b0;
      operation_q   <= '0;
      cur_mem_q     <= '0;
      memtype_q     <= '0;
      af_q          <= '0;
      eei_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      pass_q        <= '0;
      fail_q        <= '0;
      tmo_q         <= '0;
      errd_q        <= '0;
      err_count_q   <= '0;
    end else begin
      remaining_q   <= remaining_d;
      algo_q        <= algo_d;
      memtype_cfg_q <= memtype_cfg_d;
      af_cfg_q      <= af_cfg_d;
      ign_cfg_q     <= ign_cfg_d;
      to_q          <= to_d;
      cfg_cnt_q     <= cfg_cnt_d;
      wd_q          <= wd_d;
      err_prev_q    <= err_prev_d;
      test_mode_q   <= test_mode_d;
      operation_q   <= operation_d;
      cur_mem_q     <= cur_mem_d;
      memtype_q     <= memtype_d;
      af_q          <= af_d;
      eei_q         <= eei_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      tmo_q         <= tmo_d;
      errd_q        <= errd_d;
      err_count_q   <= err_count_d;
    end
  end

  assign eng.test_mode           = test_mode_q;
  assign eng.operation           = operation_q;
  assign eng.memory_sel          = cur_mem_q;
  assign eng.memtype             = memtype_q;
  assign eng.allowable_faulty    = af_q;
  assign eng.error_exceed_ignore = eei_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign aborted                 = aborted_q;
  assign cur_mem                 = cur_mem_q;
  assign pass_mask               = pass_q;
  assign fail_mask               = fail_q;
  assign timeout_mask            = tmo_q;
  assign errored_mask            = errd_q;
  assign err_count               = err_count_q;

endmodule

// File: tb/tb_mbist_scheduler.sv
// Directed bench for mbist_scheduler with a small behavioural engine model.
module tb_mbist_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, abort, ignore_cfg;
  logic [7:0]  mem_enable;
  logic [2:0]  algo_sel;
  logic [39:0] memtype_cfg;
  logic [15:0] allowable_faulty_cfg;
  logic [31:0] timeout_cycles;
  logic        busy, done, aborted;
  logic [2:0]  cur_mem;
  logic [7:0]  pass_mask, fail_mask, timeout_mask, errored_mask;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  // Engine model controls: per-memory mode (0 complete, 1 force_terminate, 2 silent,
  // 3 complete+force_terminate with three error pulses) and response delay
  int mode_tab [8];
  int resp_delay;

  // Monitor record of test_mode windows
  int win_cnt  = 0;
  int done_cnt = 0;
  int win_len [64];
  int win_sel [64];
  int win_gap [64];

  always #5 clk = ~clk;

  mbist_scheduler_if #(.ADDR_WIDTH(16)) bus ();

  mbist_scheduler #(
    .NUM_MEM(8), .ADDR_WIDTH(16), .CFG_CYCLES(4), .TO_WIDTH(32)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .mem_enable           (mem_enable),
    .algo_sel             (algo_sel),
    .memtype_cfg          (memtype_cfg),
    .allowable_faulty_cfg (allowable_faulty_cfg),
    .ignore_cfg           (ignore_cfg),
    .timeout_cycles       (timeout_cycles),
    .eng                  (bus),
    .busy                 (busy),
    .done                 (done),
    .aborted              (aborted),
    .cur_mem              (cur_mem),
    .pass_mask            (pass_mask),
    .fail_mask            (fail_mask),
    .timeout_mask         (timeout_mask),
    .errored_mask         (errored_mask),
    .err_count            (err_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_session(input logic [7:0] en);
    mem_enable = en;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    check(tag, seen, 1'b1);
  endtask

  // Engine model: arms on the falling edge of test_mode, responds after resp_delay cycles
  initial begin : engine
    int  cnt;
    int  m;
    logic tm_prev;
    cnt = -1; m = 0; tm_prev = 1'b0;
    bus.complete = 1'b0; bus.force_terminate = 1'b0; bus.error = 1'b0;
    forever begin
      @(negedge clk);
      bus.complete = 1'b0; bus.force_terminate = 1'b0; bus.error = 1'b0;
      if (busy !== 1'b1) begin
        cnt = -1;
      end else if (tm_prev && bus.test_mode === 1'b0) begin
        cnt = resp_delay;
        m   = mode_tab[bus.memory_sel];
      end else if (cnt > 0) begin
        cnt--;
        if (m == 3 && (cnt == 10 || cnt == 8 || cnt == 6)) bus.error = 1'b1;
        if (cnt == 0) begin
          case (m)
            0: bus.complete = 1'b1;
            1: bus.force_terminate = 1'b1;
            3: begin bus.complete = 1'b1; bus.force_terminate = 1'b1; end
            default: ;
          endcase
          cnt = -1;
        end
      end
      tm_prev = (bus.test_mode === 1'b1);
    end
  end

  // Window monitor: length, selected memory and preceding low gap of each test_mode window
  initial begin : monitor
    logic tm, tm_prev;
    int   len, gap;
    tm_prev = 1'b0; len = 0; gap = 0;
    forever begin
      @(negedge clk);
      tm = (bus.test_mode === 1'b1);
      if (tm) begin
        if (!tm_prev) begin
          win_sel[win_cnt % 64] = int'(bus.memory_sel);
          win_gap[win_cnt % 64] = gap;
          len = 0;
        end
        len++;
        win_len[win_cnt % 64] = len;
      end else begin
        if (tm_prev) begin
          win_cnt++;
          gap = 0;
        end
        gap++;
      end
      if (done === 1'b1) done_cnt++;
      tm_prev = tm;
    end
  end

  initial begin : main
    int base, dbase;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mem_enable = '0; algo_sel = 3'd0;
    allowable_faulty_cfg = 16'h0123; ignore_cfg = 1'b1; timeout_cycles = '0;
    for (int i = 0; i < 8; i++) begin
      memtype_cfg[5*i +: 5] = 5'(i + 3);
      mode_tab[i] = 0;
    end
    resp_delay = 100;
    tick(); tick(); tick();
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst test_mode", bus.test_mode, 1'b0);
    check("rst pass_mask", pass_mask, 8'h00);
    check("rst err_count", err_count, 16'h0000);
    check("rst memory_sel", bus.memory_sel, 3'd0);
    rst = 1'b0;
    tick();

    // Two passing memories
    base = win_cnt; dbase = done_cnt;
    start_session(8'h05);
    check("t1 select busy", busy, 1'b1);
    check("t1 select test_mode", bus.test_mode, 1'b0);
    tick();
    check("t1 cfg test_mode", bus.test_mode, 1'b1);
    check("t1 cfg memory_sel", bus.memory_sel, 3'd0);
    check("t1 cfg memtype", bus.memtype, 5'd3);
    check("t1 cfg allowable", bus.allowable_faulty, 16'h0123);
    check("t1 cfg ignore", bus.error_exceed_ignore, 1'b1);
    wait_done("t1 done seen");
    tick();
    check("t1 done pulse width", done, 1'b0);
    check("t1 idle busy", busy, 1'b0);
    check("t1 pass_mask", pass_mask, 8'h05);
    check("t1 fail_mask", fail_mask, 8'h00);
    check("t1 timeout_mask", timeout_mask, 8'h00);
    check("t1 windows", win_cnt - base, 2);
    check("t1 win0 len", win_len[base % 64], 4);
    check("t1 win1 len", win_len[(base + 1) % 64], 4);
    check("t1 win0 sel", win_sel[base % 64], 0);
    check("t1 win1 sel", win_sel[(base + 1) % 64], 2);
    check("t1 done count", done_cnt - dbase, 1);
    check("t1 memtype hold", bus.memtype, 5'd5);

    // Force-terminate on memory 1, memory 3 still runs
    algo_sel = 3'd1; mode_tab[1] = 1; mode_tab[3] = 0; resp_delay = 30;
    base = win_cnt;
    start_session(8'h0A);
    wait_done("t2 done seen");
    tick();
    check("t2 fail_mask", fail_mask, 8'h02);
    check("t2 pass_mask", pass_mask, 8'h08);
    check("t2 operation", bus.operation, 3'd1);
    check("t2 cur_mem", cur_mem, 3'd3);
    check("t2 win0 sel", win_sel[base % 64], 1);
    check("t2 win1 sel", win_sel[(base + 1) % 64], 3);

    // Watchdog timeout on a silent memory 0
    timeout_cycles = 32'd50; mode_tab[0] = 2; mode_tab[1] = 0; resp_delay = 20;
    base = win_cnt;
    start_session(8'h03);
    wait_done("t3 done seen");
    tick();
    check("t3 timeout_mask", timeout_mask, 8'h01);
    check("t3 pass_mask", pass_mask, 8'h02);
    check("t3 fail_mask", fail_mask, 8'h00);
    check("t3 run gap", win_gap[(base + 1) % 64], 51);
    timeout_cycles = '0;

    // Simultaneous complete and force_terminate, three error pulses
    mode_tab[0] = 3; resp_delay = 30;
    start_session(8'h01);
    wait_done("t4 done seen");
    tick();
    check("t4 fail_mask", fail_mask, 8'h01);
    check("t4 pass_mask", pass_mask, 8'h00);
    check("t4 err_count", err_count, 16'd3);
    check("t4 errored_mask", errored_mask, 8'h01);

    // Abort during memory 1 of three; start during the session is ignored
    for (int i = 0; i < 8; i++) mode_tab[i] = 0;
    resp_delay = 40;
    base = win_cnt;
    start_session(8'h07);
    for (int k = 0; k < 1000 && win_cnt < base + 2; k++) tick();
    check("t5 reached mem1 run", win_cnt >= base + 2, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("t5 done", done, 1'b1);
    check("t5 aborted", aborted, 1'b1);
    check("t5 test_mode", bus.test_mode, 1'b0);
    tick();
    check("t5 done pulse width", done, 1'b0);
    tick();
    check("t5 start ignored", busy, 1'b0);
    check("t5 pass_mask", pass_mask, 8'h01);
    check("t5 fail_mask", fail_mask, 8'h00);
    check("t5 timeout_mask", timeout_mask, 8'h00);
    check("t5 err_count cleared", err_count, 16'd0);
    check("t5 errored cleared", errored_mask, 8'h00);
    check("t5 windows", win_cnt - base, 2);

    // Empty enable mask
    start_session(8'h00);
    check("t6 select busy", busy, 1'b1);
    check("t6 select done", done, 1'b0);
    tick();
    check("t6 done", done, 1'b1);
    tick();
    check("t6 busy", busy, 1'b0);
    check("t6 aborted cleared", aborted, 1'b0);
    check("t6 pass_mask", pass_mask, 8'h00);

    // Reset mid-RUN
    resp_delay = 100;
    base = win_cnt;
    start_session(8'h03);
    for (int k = 0; k < 1000 && win_cnt < base + 2; k++) tick();
    check("t7 reached mem1 run", win_cnt >= base + 2, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("t7 pre-rst pass_mask", pass_mask, 8'h01);
    check("t7 pre-rst cur_mem", cur_mem, 3'd1);
    rst = 1'b1;
    tick();
    check("t7 rst test_mode", bus.test_mode, 1'b0);
    check("t7 rst busy", busy, 1'b0);
    check("t7 rst pass_mask", pass_mask, 8'h00);
    check("t7 rst cur_mem", cur_mem, 3'd0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
